nios2_cordic_sysid_checker: RTL and testbench

Avalon-MM read master that queries the system-ID slave at power-up or on request. It reads the ID word (word address 0) and the build timestamp (word address 1), and compares both against parameterised expected values. It reports pass/fail, the captured values and a timeout flag to the boot/status logic. It sits beside the Nios II master on the same interconnect and lets hardware refuse to release the CPU on a bitstream/software mismatch.

---
 rtl/nios2_cordic_pkg.sv | 24 ++
 rtl/nios2_cordic_avmm_read_port.sv | 71 +++++++
 rtl/nios2_cordic_sysid_checker.sv | 143 ++++++++++++++
 tb/tb_nios2_cordic_sysid_checker.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_cordic_pkg.sv
// +--------------------------------------------------------------------------+
// | nios2_cordic_pkg: shared types and constants for the system-ID checker   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package nios2_cordic_pkg;

  localparam int SYSID_DATA_W  = 32;
  localparam int SYSID_ID_ADDR = 0;
  localparam int SYSID_TS_ADDR = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ID_REQ = 3'd1,
    ST_ID_RSP = 3'd2,
    ST_TS_REQ = 3'd3,
    ST_TS_RSP = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/nios2_cordic_avmm_read_port.sv
// +--------------------------------------------------------------------------+
// | nios2_cordic_avmm_read_port: single-transaction Avalon-MM read engine    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module nios2_cordic_avmm_read_port
  import nios2_cordic_pkg::*;
#(
  parameter int ADDR_W         = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_launch,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic                    i_waitrequest,
  input  logic [SYSID_DATA_W-1:0] i_readdata,
  input  logic                    i_readdatavalid,
  output logic                    o_read,
  output logic [ADDR_W-1:0]       o_address,
  output logic                    o_accept,
  output logic                    o_rsp_valid,
  output logic [SYSID_DATA_W-1:0] o_rsp_data,
  output logic                    o_timeout
);

  localparam int                 c_CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic               r_active;
  logic               r_read;
  logic [ADDR_W-1:0]  r_address;
  logic [c_CNT_W-1:0] r_count;

  assign o_read      = r_read;
  assign o_address   = r_address;
  assign o_accept    = r_read & ~i_waitrequest;
  // A response only belongs to us once the request has been accepted.
  assign o_rsp_valid = r_active & i_readdatavalid & (o_accept | ~r_read);
  assign o_rsp_data  = i_readdata;
  // The last counted cycle is the final chance to respond; a late reply loses.
  assign o_timeout   = r_active & ~o_rsp_valid & (r_count == c_CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_read    <= 1'b0;
      r_address <= '0;
      r_count   <= '0;
    end else if (i_launch) begin
      r_active  <= 1'b1;
      r_read    <= 1'b1;
      r_address <= i_addr;
      r_count   <= '0;
    end else if (r_active) begin
      if (o_rsp_valid || o_timeout) begin
        r_active <= 1'b0;
        r_read   <= 1'b0;
      end else begin
        r_count <= r_count + c_CNT_W'(1);
        if (o_accept) begin
          r_read <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/nios2_cordic_sysid_checker.sv
// +--------------------------------------------------------------------------+
// | nios2_cordic_sysid_checker: reads system-ID and timestamp, checks match  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module nios2_cordic_sysid_checker
  import nios2_cordic_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1457457978,
  parameter int                      ADDR_W             = 1,
  parameter int                      TIMEOUT_CYCLES     = 255,
  parameter bit                      AUTO_START         = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    read,
  output logic [ADDR_W-1:0]       address,
  input  logic                    waitrequest,
  input  logic [SYSID_DATA_W-1:0] readdata,
  input  logic                    readdatavalid,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [SYSID_DATA_W-1:0] id_value,
  output logic [SYSID_DATA_W-1:0] ts_value,
  output logic                    timeout
);

  state_t                  r_state;
  logic                    r_armed;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic                    r_timeout;
  logic [SYSID_DATA_W-1:0] r_id_value;
  logic [SYSID_DATA_W-1:0] r_ts_value;

  logic                    w_accept;
  logic                    w_rsp_valid;
  logic [SYSID_DATA_W-1:0] w_rsp_data;
  logic                    w_rsp_timeout;
  logic                    w_kick;
  logic                    w_in_id;
  logic                    w_launch;
  logic [ADDR_W-1:0]       w_launch_addr;

  assign w_kick        = (r_state == ST_IDLE) && (start || (AUTO_START && r_armed));
  assign w_in_id       = (r_state == ST_ID_REQ) || (r_state == ST_ID_RSP);
  // The timestamp read launches in the same cycle the ID word lands.
  assign w_launch      = w_kick || (w_in_id && w_rsp_valid);
  assign w_launch_addr = (r_state == ST_IDLE) ? ADDR_W'(SYSID_ID_ADDR) : ADDR_W'(SYSID_TS_ADDR);

  nios2_cordic_avmm_read_port #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_read_port (
    .clk             (clock),
    .rst             (reset),
    .i_launch        (w_launch),
    .i_addr          (w_launch_addr),
    .i_waitrequest   (waitrequest),
    .i_readdata      (readdata),
    .i_readdatavalid (readdatavalid),
    .o_read          (read),
    .o_address       (address),
    .o_accept        (w_accept),
    .o_rsp_valid     (w_rsp_valid),
    .o_rsp_data      (w_rsp_data),
    .o_timeout       (w_rsp_timeout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= '0;
      r_ts_value <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_kick) begin
            r_state   <= ST_ID_REQ;
            r_armed   <= 1'b0;
            r_busy    <= 1'b1;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
          end
        end
        ST_ID_REQ, ST_ID_RSP: begin
          if (w_rsp_valid) begin
            r_id_value <= w_rsp_data;
            r_state    <= ST_TS_REQ;
          end else if (w_rsp_timeout) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_FIN;
          end else if ((r_state == ST_ID_REQ) && w_accept) begin
            r_state <= ST_ID_RSP;
          end
        end
        ST_TS_REQ, ST_TS_RSP: begin
          if (w_rsp_valid) begin
            r_ts_value <= w_rsp_data;
            r_pass     <= (r_id_value == EXPECTED_ID) && (w_rsp_data == EXPECTED_TIMESTAMP);
            r_done     <= 1'b1;
            r_state    <= ST_FIN;
          end else if (w_rsp_timeout) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_FIN;
          end else if ((r_state == ST_TS_REQ) && w_accept) begin
            r_state <= ST_TS_RSP;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule

`default_nettype wire

// File: tb/tb_nios2_cordic_sysid_checker.sv
// +--------------------------------------------------------------------------+
// | tb_nios2_cordic_sysid_checker: randomized scoreboard bench for checker   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_nios2_cordic_sysid_checker;

  localparam int          T      = 8;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1457457978;

  logic        clock = 1'b0;
  logic        reset;
  logic        start = 1'b0;
  logic        read;
  logic [0:0]  address;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;
  logic        readdatavalid = 1'b0;
  logic        busy, done, pass, timeout;
  logic [31:0] id_value, ts_value;

  nios2_cordic_sysid_checker #(
    .EXPECTED_ID        (EXP_ID),
    .EXPECTED_TIMESTAMP (EXP_TS),
    .ADDR_W             (1),
    .TIMEOUT_CYCLES     (T),
    .AUTO_START         (1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .read          (read),
    .address       (address),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .id_value      (id_value),
    .ts_value      (ts_value),
    .timeout       (timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave behaviour per address: stall cycles, response latency, silence.
  int          pl_wait [2];
  int          pl_lat  [2];
  bit          pl_nr   [2];
  logic [31:0] pl_mem  [2];

  typedef struct {
    int          done_cyc;
    logic [31:0] id;
    logic [31:0] ts;
    bit          pass;
    bit          tmo;
    int          n_id;
    int          n_ts;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_id = '0;
  logic [31:0] m_ts = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Outcome of one check from the slave plan, in whole-transaction terms.
  task automatic push_expect(input int sc);
    exp_t e;
    int   k0, k1;
    k0       = pl_wait[0] + pl_lat[0];
    k1       = pl_wait[1] + pl_lat[1];
    e.n_id   = 1;
    e.n_ts   = 0;
    e.pass   = 1'b0;
    e.tmo    = 1'b0;
    if (pl_nr[0] || k0 >= T) begin
      e.tmo      = 1'b1;
      e.done_cyc = sc + T + 1;
    end else begin
      m_id   = pl_mem[0];
      e.n_ts = 1;
      if (pl_nr[1] || k1 >= T) begin
        e.tmo      = 1'b1;
        e.done_cyc = sc + 2 + k0 + T;
      end else begin
        m_ts       = pl_mem[1];
        e.pass     = (m_id == EXP_ID) && (m_ts == EXP_TS);
        e.done_cyc = sc + 3 + k0 + k1;
      end
    end
    e.id = m_id;
    e.ts = m_ts;
    exp_q.push_back(e);
  endtask

  task automatic set_plan(input int w0, input int l0, input int w1, input int l1,
                          input bit n0, input bit n1, input logic [31:0] v0, input logic [31:0] v1);
    pl_wait[0] = w0; pl_lat[0] = l0; pl_nr[0] = n0; pl_mem[0] = v0;
    pl_wait[1] = w1; pl_lat[1] = l1; pl_nr[1] = n1; pl_mem[1] = v1;
  endtask

  // Waits for done while hammering start during busy (which must be ignored).
  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
      start = busy ? 1'($urandom_range(1)) : 1'b0;
    end
    @(negedge clock);
    start = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_done_timeout: got no done required done within 80 cycles", tag);
      exp_q.delete();
    end
    repeat ($urandom_range(3)) @(negedge clock);
  endtask

  task automatic issue(input string tag);
    push_expect(cyc);
    start = 1'b1;
    wait_done(tag);
  endtask

  // Slave: decides the inputs for the coming rising edge at each falling edge.
  initial begin : slave
    bit         in_req, pend;
    int         w, lat;
    logic [0:0] a;
    in_req = 1'b0; pend = 1'b0; w = 0; lat = 0; a = '0;
    forever begin
      @(negedge clock);
      waitrequest   = 1'b0;
      readdatavalid = 1'b0;
      readdata      = $urandom;
      if (!read) in_req = 1'b0;
      if (!busy && !read) pend = 1'b0;
      if (pend) begin
        if (lat == 0) begin
          readdatavalid = 1'b1;
          readdata      = pl_mem[a];
          pend          = 1'b0;
        end else begin
          lat--;
        end
      end else if (read) begin
        if (!in_req) begin
          in_req = 1'b1;
          a      = address;
          w      = pl_wait[a];
          lat    = pl_lat[a];
        end
        if (w > 0) begin
          waitrequest = 1'b1;
          w--;
        end else begin
          in_req = 1'b0;
          if (!pl_nr[a]) begin
            if (lat == 0) begin
              readdatavalid = 1'b1;
              readdata      = pl_mem[a];
            end else begin
              pend = 1'b1;
              lat--;
            end
          end
        end
      end else if (!busy && $urandom_range(3) == 0) begin
        readdatavalid = 1'b1;
      end
    end
  end

  // Monitor: bus hold during stalls, request counting, scoreboard on done.
  initial begin : monitor
    bit         p_read, p_wr;
    logic [0:0] p_addr;
    int         n_id, n_ts;
    exp_t       e;
    p_read = 1'b0; p_wr = 1'b0; p_addr = '0; n_id = 0; n_ts = 0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        n_id = 0; n_ts = 0; p_read = 1'b0; p_wr = 1'b0;
      end else begin
        if (p_read && p_wr) begin
          chk("stall_read_hold", read, 1);
          chk("stall_addr_hold", address, p_addr);
        end
        if (read && (!p_read || !p_wr)) begin
          if (address == 1'b0) n_id++;
          else n_ts++;
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: got done=1 required no done (t=%0t)", $time);
          end else begin
            e = exp_q.pop_front();
            chk("done_cycle", cyc, e.done_cyc);
            chk("pass", pass, e.pass);
            chk("timeout", timeout, e.tmo);
            chk("id_value", id_value, e.id);
            chk("ts_value", ts_value, e.ts);
            chk("id_reads", n_id, e.n_id);
            chk("ts_reads", n_ts, e.n_ts);
          end
          n_id = 0;
          n_ts = 0;
        end
        p_read = read;
        p_wr   = waitrequest;
        p_addr = address;
      end
    end
  end

  initial begin : driver
    reset = 1'b1;
    set_plan(0, 0, 0, 0, 1'b0, 1'b0, EXP_ID, EXP_TS);
    repeat (3) @(negedge clock);
    chk("rst_read", read, 0);
    chk("rst_address", address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_id", id_value, 0);
    chk("rst_ts", ts_value, 0);

    // Auto-start with a zero-wait, zero-latency slave.
    reset = 1'b0;
    push_expect(cyc);
    wait_done("auto");

    set_plan(0, 0, 0, 0, 1'b0, 1'b0, 32'd5, EXP_TS);
    issue("bad_id");
    set_plan(4, 2, 0, 0, 1'b0, 1'b0, EXP_ID, EXP_TS);
    issue("stall");
    set_plan(0, 0, 0, 0, 1'b1, 1'b0, 32'd7, 32'd9);
    issue("id_silent");
    set_plan(1, 1, 2, 3, 1'b0, 1'b0, EXP_ID, EXP_TS);
    issue("second");
    set_plan(0, 1, 0, 0, 1'b0, 1'b1, 32'd3, EXP_TS);
    issue("ts_silent");

    // Reset while waiting for the ID response.
    set_plan(0, 6, 0, 0, 1'b0, 1'b0, 32'hA5A5_0001, 32'h1234);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("rsp_read", read, 0);
    chk("rsp_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("async_read", read, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_pass", pass, 0);
    chk("async_timeout", timeout, 0);
    chk("async_id", id_value, 0);
    chk("async_ts", ts_value, 0);
    exp_q.delete();
    m_id = '0;
    m_ts = '0;
    repeat (2) @(negedge clock);
    set_plan(0, 0, 0, 0, 1'b0, 1'b0, EXP_ID, EXP_TS);
    reset = 1'b0;
    push_expect(cyc);
    wait_done("rearm");

    for (int i = 0; i < 30; i++) begin
      set_plan(int'($urandom_range(5)), int'($urandom_range(4)),
               int'($urandom_range(5)), int'($urandom_range(4)),
               ($urandom_range(7) == 0), ($urandom_range(7) == 0),
               ($urandom_range(1) == 0) ? EXP_ID : $urandom,
               ($urandom_range(1) == 0) ? EXP_TS : $urandom);
      issue("rand");
    end

    repeat (5) @(negedge clock);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
